// File: rtl/rvvi_pkg.sv
// Shared definitions for the RVVI trace packetiser: header layout and FSM state encoding.
package rvvi_pkg;

  localparam logic [15:0] RVVI_MAGIC = 16'h5256;

  localparam int unsigned HDR_WORDS_LSB = 0;
  localparam int unsigned HDR_CH_LSB    = 8;
  localparam int unsigned HDR_MAGIC_LSB = 16;

  typedef enum logic [2:0] {INIT, ARB, HEADER, PAYLOAD, GAP} rvvi_pkt_state_t;

  function automatic logic [31:0] rvvi_header(input logic [7:0] ch, input logic [7:0] words);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = RVVI_MAGIC;
    h[HDR_CH_LSB    +: 8]  = ch;
    h[HDR_WORDS_LSB +: 8]  = words;
    return h;
  endfunction

endpackage

// File: rtl/rvvi_chan_fifo.sv
// Per-channel record FIFO; the head record stays put until popped so a packet in flight is never disturbed.
module rvvi_chan_fifo #(
  parameter int unsigned WIDTH = 448,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(DEPTH - 1));
  assign do_pop      = pop && !empty;
  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign do_push     = push && (!full || do_pop);
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rvvi_mc_packetizer.sv
// Multi-hart RVVI trace serialiser: per-channel FIFOs, round-robin arbitration and
// header + payload framing onto an AXI4-Stream byte-lane bus.
module rvvi_mc_packetizer
  import rvvi_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned RVVI_WIDTH    = 448,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [31:0] INIT_TIME_OUT = 32'd4,
  parameter logic [31:0] PACKET_DELAY  = 32'd2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 RvviValid,
  input  logic [NUM_CH-1:0][RVVI_WIDTH-1:0] Rvvi,
  output logic                              ExternalStall,
  output logic [DATA_WIDTH-1:0]             TData,
  output logic [DATA_WIDTH/8-1:0]           TKeep,
  output logic                              TValid,
  output logic                              TLast,
  input  logic                              TReady,
  output logic [31:0]                       PacketCount,
  output logic [NUM_CH-1:0]                 Overflow
);

  localparam int unsigned WORDS = (RVVI_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned KW    = DATA_WIDTH / 8;
  localparam int unsigned REM   = (RVVI_WIDTH / 8) % KW;
  localparam logic [KW-1:0] LAST_KEEP = (REM == 0) ? {KW{1'b1}} : KW'((1 << REM) - 1);
  localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  // Both waits include the ARB cycle, so the header lands exactly INIT_TIME_OUT
  // cycles after reset and PACKET_DELAY idle cycles after tlast (minimum one).
  localparam int unsigned INIT_CYC = (INIT_TIME_OUT > 1) ? INIT_TIME_OUT - 1 : 1;
  localparam int unsigned GAP_CYC  = (PACKET_DELAY > 1) ? PACKET_DELAY - 1 : 0;
  localparam int unsigned MAXT     = (INIT_CYC > GAP_CYC) ? INIT_CYC : GAP_CYC;
  localparam int unsigned TW       = (MAXT > 1) ? $clog2(MAXT) : 1;

  rvvi_pkt_state_t state, state_next;

  logic [TW-1:0]          tmr;
  logic [BW-1:0]          beat;
  logic [CHW-1:0]         cur_ch;
  logic [CHW-1:0]         rr;
  logic [CHW-1:0]         rr_next;
  logic [CHW:0]           rr_inc;
  logic [CHW:0]           arb_idx;
  logic [CHW-1:0]         arb_ch;
  logic                   arb_found;
  logic                   last_beat;
  logic                   last_hs;

  logic [NUM_CH-1:0]      pop;
  logic [NUM_CH-1:0]      full;
  logic [NUM_CH-1:0]      empty;
  logic [NUM_CH-1:0]      afull;
  logic [RVVI_WIDTH-1:0]  head [NUM_CH];
  logic [WORDS-1:0][DATA_WIDTH-1:0] cur_words;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign pop[g] = last_hs && (cur_ch == CHW'(g));

    rvvi_chan_fifo #(
      .WIDTH (RVVI_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (RvviValid[g]),
      .din         (Rvvi[g]),
      .pop         (pop[g]),
      .head        (head[g]),
      .full        (full[g]),
      .empty       (empty[g]),
      .almost_full (afull[g])
    );
  end

  assign cur_words = (WORDS * DATA_WIDTH)'(head[cur_ch]);
  assign last_beat = (beat == BW'(WORDS - 1));
  assign last_hs   = (state == PAYLOAD) && TReady && last_beat;

  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      arb_idx = {1'b0, rr} + (CHW + 1)'(i);
      if (arb_idx >= (CHW + 1)'(NUM_CH)) arb_idx = arb_idx - (CHW + 1)'(NUM_CH);
      if (!arb_found && !empty[arb_idx[CHW-1:0]]) begin
        arb_found = 1'b1;
        arb_ch    = arb_idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    rr_inc  = {1'b0, arb_ch} + 1'b1;
    rr_next = (rr_inc >= (CHW + 1)'(NUM_CH)) ? '0 : rr_inc[CHW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (tmr == TW'(INIT_CYC - 1)) state_next = ARB;
      ARB:     if (arb_found) state_next = HEADER;
      HEADER:  if (TReady) state_next = PAYLOAD;
      PAYLOAD: if (last_hs) state_next = (GAP_CYC == 0) ? ARB : GAP;
      GAP:     if (tmr == TW'(GAP_CYC - 1)) state_next = ARB;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    TValid = 1'b0;
    TLast  = 1'b0;
    TData  = '0;
    TKeep  = '0;
    case (state)
      HEADER: begin
        TValid      = 1'b1;
        TData[31:0] = rvvi_header(8'(cur_ch), 8'(WORDS));
        TKeep       = '1;
      end
      PAYLOAD: begin
        TValid = 1'b1;
        TData  = cur_words[beat];
        TLast  = last_beat;
        TKeep  = last_beat ? LAST_KEEP : '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr           <= '0;
      beat          <= '0;
      cur_ch        <= '0;
      rr            <= '0;
      PacketCount   <= '0;
      ExternalStall <= 1'b0;
      Overflow      <= '0;
    end else begin
      ExternalStall <= |afull;
      Overflow      <= Overflow | (RvviValid & full & ~pop);
      tmr           <= (state_next != state) ? '0 : tmr + 1'b1;
      if (state == ARB && arb_found) begin
        cur_ch <= arb_ch;
        rr     <= rr_next;
      end
      if (state == HEADER)                beat <= '0;
      else if (state == PAYLOAD && TReady) beat <= beat + 1'b1;
      if (last_hs) PacketCount <= PacketCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_rvvi_mc_packetizer.sv
// Directed bench for rvvi_mc_packetizer: framing, arbitration order, gaps, backpressure,
// stall/overflow, a 440-bit record variant and reset in mid-packet.
module tb_rvvi_mc_packetizer;
  import rvvi_pkg::*;

  localparam int unsigned NCH   = 2;
  localparam int unsigned RW    = 448;
  localparam int unsigned RW2   = 440;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 14;
  localparam logic [3:0]  LAST_KEEP   = 4'hF;   // 56 bytes, whole last word
  localparam logic [3:0]  LAST_KEEP_B = 4'b0111; // 55 bytes: 55 mod 4 = 3 bytes

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0]         RvviValid;
  logic [NCH-1:0][RW-1:0] Rvvi;
  logic                   ExternalStall, TValid, TLast, TReady;
  logic [DW-1:0]          TData;
  logic [3:0]             TKeep;
  logic [31:0]            PacketCount;
  logic [NCH-1:0]         Overflow;

  logic [NCH-1:0]          RvviValid_b;
  logic [NCH-1:0][RW2-1:0] Rvvi_b;
  logic                    ExternalStall_b, TValid_b, TLast_b, TReady_b;
  logic [DW-1:0]           TData_b;
  logic [3:0]              TKeep_b;
  logic [31:0]             PacketCount_b;
  logic [NCH-1:0]          Overflow_b;

  rvvi_mc_packetizer #(
    .NUM_CH(NCH), .RVVI_WIDTH(RW), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
    .INIT_TIME_OUT(32'd4), .PACKET_DELAY(32'd2)
  ) dut (
    .clk(clk), .reset(reset), .RvviValid(RvviValid), .Rvvi(Rvvi),
    .ExternalStall(ExternalStall), .TData(TData), .TKeep(TKeep), .TValid(TValid),
    .TLast(TLast), .TReady(TReady), .PacketCount(PacketCount), .Overflow(Overflow)
  );

  rvvi_mc_packetizer #(
    .NUM_CH(NCH), .RVVI_WIDTH(RW2), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
    .INIT_TIME_OUT(32'd4), .PACKET_DELAY(32'd2)
  ) dut_b (
    .clk(clk), .reset(reset), .RvviValid(RvviValid_b), .Rvvi(Rvvi_b),
    .ExternalStall(ExternalStall_b), .TData(TData_b), .TKeep(TKeep_b), .TValid(TValid_b),
    .TLast(TLast_b), .TReady(TReady_b), .PacketCount(PacketCount_b), .Overflow(Overflow_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int r0 = 0;

  typedef struct {
    logic [1:0] push;
    int         tag0;
    int         tag1;
    int         exp_ch;
    int         exp_tag;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] make_rec(input int tag);
    logic [RW-1:0] r;
    r = '0;
    for (int b = 0; b < int'(RW / 8); b++) r[b*8 +: 8] = 8'(tag * 29 + b * 7 + 3);
    return r;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    RvviValid = '0;
    RvviValid_b = '0;
    TReady    = 1'b0;
    TReady_b  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    r0    = cyc;
  endtask

  // Receives one packet, randomising TReady at pct% and checking each beat at its handshake.
  task automatic recv_packet(input string name, input int exp_ch, input int exp_tag, input int pct,
                             input logic [1:0] lpush, input int ltag,
                             output int hdr_cyc, output int last_cyc);
    logic [RW-1:0] rec;
    logic [DW-1:0] exp_d, held, got_d;
    logic [3:0]    got_k;
    logic          got_l;
    bit            moved, done;
    int            waits;
    rec = make_rec(exp_tag);
    hdr_cyc = -1;
    last_cyc = -1;
    TReady = 1'b0;
    waits = 0;
    while (TValid !== 1'b1 && waits < 300) begin
      tick();
      waits++;
    end
    if (TValid !== 1'b1) begin
      check({name, " header timeout"}, 64'(TValid), 64'd1);
      return;
    end
    hdr_cyc = cyc;
    for (int b = 0; b <= int'(WORDS); b++) begin
      exp_d = (b == 0) ? DW'(rvvi_header(8'(exp_ch), 8'(WORDS))) : rec[(b-1)*DW +: DW];
      held  = TData;
      moved = 1'b0;
      done  = 1'b0;
      waits = 0;
      got_d = '0;
      got_k = '0;
      got_l = 1'b0;
      while (!done) begin
        if (TValid !== 1'b1 || TData !== held) moved = 1'b1;
        TReady = (waits >= 200) || ($urandom_range(99) < pct);
        done  = TReady;
        got_d = TData;
        got_k = TKeep;
        got_l = TLast;
        if (TReady && b == int'(WORDS)) begin
          last_cyc = cyc;
          if (lpush != '0) begin
            RvviValid = lpush;
            for (int c = 0; c < int'(NCH); c++) Rvvi[c] = make_rec(ltag);
          end
        end
        tick();
        RvviValid = '0;
        waits++;
      end
      check($sformatf("%s beat%0d data", name, b), 64'(got_d), 64'(exp_d));
      check($sformatf("%s beat%0d keep", name, b), 64'(got_k), 64'((b == int'(WORDS)) ? LAST_KEEP : 4'hF));
      check($sformatf("%s beat%0d last", name, b), 64'(got_l), 64'(b == int'(WORDS)));
      check($sformatf("%s beat%0d stable", name, b), 64'(moved), 64'd0);
    end
    TReady = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    int hdr [3];
    int lst [3];
    int h, l, waits;
    logic [RW-1:0] rec;

    vecs[0] = '{push: 2'b11, tag0: 10, tag1: 11, exp_ch: 0, exp_tag: 10};
    vecs[1] = '{push: 2'b10, tag0: 0,  tag1: 12, exp_ch: 1, exp_tag: 11};
    vecs[2] = '{push: 2'b00, tag0: 0,  tag1: 0,  exp_ch: 1, exp_tag: 12};

    Rvvi = '0;
    Rvvi_b = '0;

    // Single record on ch0: reset state, init timeout, framing, PacketCount.
    do_reset();
    check("rst TValid", 64'(TValid), 64'd0);
    check("rst TLast", 64'(TLast), 64'd0);
    check("rst TData", 64'(TData), 64'd0);
    check("rst TKeep", 64'(TKeep), 64'd0);
    check("rst ExternalStall", 64'(ExternalStall), 64'd0);
    check("rst PacketCount", 64'(PacketCount), 64'd0);
    check("rst Overflow", 64'(Overflow), 64'd0);
    RvviValid = 2'b01;
    Rvvi[0] = make_rec(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init idle c%0d", i), 64'(TValid), 64'd0);
      tick();
      RvviValid = '0;
    end
    recv_packet("single", 0, 1, 100, 2'b00, 0, h, l);
    check("single header cycle", 64'(h - r0), 64'd4);
    check("single PacketCount", 64'(PacketCount), 64'd1);

    // Table: simultaneous pushes then ch1 again; order, payload and gaps.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      RvviValid = vecs[i].push;
      Rvvi[0] = make_rec(vecs[i].tag0);
      Rvvi[1] = make_rec(vecs[i].tag1);
      tick();
    end
    RvviValid = '0;
    for (int i = 0; i < 3; i++) begin
      recv_packet($sformatf("rr%0d", i), vecs[i].exp_ch, vecs[i].exp_tag, 100, 2'b00, 0, hdr[i], lst[i]);
      if (i > 0) check($sformatf("rr gap%0d", i), 64'(hdr[i] - lst[i-1]), 64'd3);
    end
    check("rr PacketCount", 64'(PacketCount), 64'd3);

    // Random backpressure at 30%.
    do_reset();
    RvviValid = 2'b11;
    Rvvi[0] = make_rec(20);
    Rvvi[1] = make_rec(21);
    tick();
    RvviValid = 2'b01;
    Rvvi[0] = make_rec(22);
    tick();
    RvviValid = '0;
    recv_packet("bp0", 0, 20, 30, 2'b00, 0, h, l);
    recv_packet("bp1", 1, 21, 30, 2'b00, 0, h, l);
    recv_packet("bp2", 0, 22, 30, 2'b00, 0, h, l);
    check("bp Overflow", 64'(Overflow), 64'd0);

    // TReady held low while ch0 pushes every cycle: stall timing, overflow, intact records.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      if (i < 8) begin
        check($sformatf("stall c%0d", i), 64'(ExternalStall), 64'(i >= 4));
        check($sformatf("ovf c%0d", i), 64'(Overflow), 64'((i >= 5) ? 2'b01 : 2'b00));
      end
      RvviValid = 2'b01;
      Rvvi[0] = make_rec(40 + i);
      tick();
    end
    RvviValid = '0;
    check("stall held", 64'(ExternalStall), 64'd1);
    check("ovf sticky", 64'(Overflow), 64'h1);
    for (int i = 0; i < 4; i++) recv_packet($sformatf("full%0d", i), 0, 40 + i, 100, 2'b00, 0, h, l);
    check("ovf after drain", 64'(Overflow), 64'h1);

    // Push coinciding with the pop of a full FIFO must be kept without overflow.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      RvviValid = 2'b10;
      Rvvi[1] = make_rec(60 + i);
      tick();
    end
    RvviValid = '0;
    recv_packet("pp0", 1, 60, 100, 2'b10, 64, h, l);
    check("pp Overflow", 64'(Overflow), 64'd0);
    for (int i = 1; i < 5; i++) recv_packet($sformatf("pp%0d", i), 1, 60 + i, 100, 2'b00, 0, h, l);

    // 440-bit records: WORDS=14, partial last beat.
    do_reset();
    rec = make_rec(5);
    RvviValid_b = 2'b10;
    Rvvi_b[1] = rec[RW2-1:0];
    TReady_b = 1'b1;
    tick();
    RvviValid_b = '0;
    waits = 0;
    while (TValid_b !== 1'b1 && waits < 100) begin
      tick();
      waits++;
    end
    check("w440 header", 64'(TData_b), 64'h5256010E);
    for (int b = 0; b < int'(WORDS); b++) begin
      tick();
      if (b == int'(WORDS) - 2) check("w440 beat13 keep", 64'(TKeep_b), 64'hF);
      if (b == int'(WORDS) - 1) begin
        check("w440 last keep", 64'(TKeep_b), 64'(LAST_KEEP_B));
        check("w440 last flag", 64'(TLast_b), 64'd1);
        check("w440 last data", 64'(TData_b), 64'({8'h00, rec[439:416]}));
      end
    end
    tick();
    TReady_b = 1'b0;
    check("w440 PacketCount", 64'(PacketCount_b), 64'd1);
    check("w440 Overflow", 64'(Overflow_b), 64'd0);
    check("w440 stall", 64'(ExternalStall_b), 64'd0);

    // Reset on payload beat 5 of the second packet.
    do_reset();
    RvviValid = 2'b11;
    Rvvi[0] = make_rec(70);
    Rvvi[1] = make_rec(71);
    tick();
    RvviValid = '0;
    recv_packet("mid0", 0, 70, 100, 2'b00, 0, h, l);
    TReady = 1'b1;
    waits = 0;
    while (TValid !== 1'b1 && waits < 100) begin
      tick();
      waits++;
    end
    for (int i = 0; i < 5; i++) tick();
    rec = make_rec(71);
    check("mid beat5 data", 64'(TData), 64'(rec[4*DW +: DW]));
    check("mid pre PacketCount", 64'(PacketCount), 64'd1);
    reset = 1'b1;
    tick();
    check("mid rst TValid", 64'(TValid), 64'd0);
    check("mid rst TLast", 64'(TLast), 64'd0);
    check("mid rst TData", 64'(TData), 64'd0);
    check("mid rst PacketCount", 64'(PacketCount), 64'd0);
    reset = 1'b0;
    TReady = 1'b0;
    r0 = cyc;
    RvviValid = 2'b10;
    Rvvi[1] = make_rec(72);
    tick();
    RvviValid = '0;
    recv_packet("mid1", 1, 72, 100, 2'b00, 0, h, l);
    check("mid header cycle", 64'(h - r0), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
